// File: rtl/ex_muldiv_sequencer_pkg.sv
// Shared types and funct3 predicates for the EX-stage RV32M multiply/divide sequencer.
// Op decode is purely combinational; no state lives here.
package ex_muldiv_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic is_div(input muldiv_op_t op);
        return op[2];
    endfunction

    function automatic logic is_rem(input muldiv_op_t op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_a(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv_sequencer_if.sv
// EX-stage <-> mul/div engine bundle: master is the pipeline, slave is the engine.
interface ex_muldiv_sequencer_if
    import ex_muldiv_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic                  i_start;
    muldiv_op_t            i_op;
    logic [DATA_WIDTH-1:0] i_a;
    logic [DATA_WIDTH-1:0] i_b;
    logic                  i_flush;
    logic                  o_stall;
    logic                  o_done;
    logic [DATA_WIDTH-1:0] o_result;

    modport master (
        output i_start, i_op, i_a, i_b, i_flush,
        input  o_stall, o_done, o_result
    );

    modport slave (
        input  i_start, i_op, i_a, i_b, i_flush,
        output o_stall, o_done, o_result
    );
endinterface

// File: rtl/ex_muldiv_sequencer_iter_dp.sv
// One radix-2 step: shift-add multiply or restoring trial-subtract divide on {hi, lo}.
// Purely combinational, zero latency.
module ex_muldiv_sequencer_iter_dp #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  is_div_i,
    input  logic [DATA_WIDTH-1:0] hi_i,
    input  logic [DATA_WIDTH-1:0] lo_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] hi_o,
    output logic [DATA_WIDTH-1:0] lo_o
);
    logic [DATA_WIDTH:0] add_sum;
    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    always_comb begin
        add_sum = {1'b0, hi_i} + (lo_i[0] ? {1'b0, b_i} : '0);
        shifted = {hi_i, lo_i[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, b_i};
        hi_o    = '0;
        lo_o    = '0;
        if (is_div_i) begin
            // Partial remainder stays below the divisor, so diff's top bit is a true sign.
            if (!diff[DATA_WIDTH]) begin
                hi_o = diff[DATA_WIDTH-1:0];
                lo_o = {lo_i[DATA_WIDTH-2:0], 1'b1};
            end else begin
                hi_o = shifted[DATA_WIDTH-1:0];
                lo_o = {lo_i[DATA_WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_o = add_sum[DATA_WIDTH:1];
            lo_o = {add_sum[0], lo_i[DATA_WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/ex_muldiv_sequencer.sv
// RV32M mul/div sequencer: stalls EX for DATA_WIDTH iterations, then pulses o_done with the result.
// Start-to-done DATA_WIDTH+1 cycles (1 for x/0 and signed overflow); i_flush aborts at any time.
module ex_muldiv_sequencer
    import ex_muldiv_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    ex_muldiv_sequencer_if.slave  bus
);
    localparam int              CW       = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(DATA_WIDTH);
    localparam logic [DATA_WIDTH-1:0] INT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    muldiv_state_t         state_q;
    logic [CW-1:0]         cnt_q;
    muldiv_op_t            op_q;
    logic                  neg_q;
    logic [DATA_WIDTH-1:0] hi_q, lo_q, b_q;
    logic                  done_q;
    logic [DATA_WIDTH-1:0] result_q;

    logic                  start_ok, a_neg, b_neg, div_zero, ovf, neg_d;
    logic [DATA_WIDTH-1:0] a_mag, b_mag, spec_res, hi_d, lo_d, rq_sel, final_res;
    logic [2*DATA_WIDTH-1:0] prod, prod_fix;

    ex_muldiv_sequencer_iter_dp #(.DATA_WIDTH(DATA_WIDTH)) u_iter_dp (
        .is_div_i (is_div(op_q)),
        .hi_i     (hi_q),
        .lo_i     (lo_q),
        .b_i      (b_q),
        .hi_o     (hi_d),
        .lo_o     (lo_d)
    );

    always_comb begin
        start_ok = (state_q == ST_IDLE) && bus.i_start && !bus.i_flush;
        a_neg    = is_signed_a(bus.i_op) && bus.i_a[DATA_WIDTH-1];
        b_neg    = is_signed_b(bus.i_op) && bus.i_b[DATA_WIDTH-1];
        a_mag    = a_neg ? -bus.i_a : bus.i_a;
        b_mag    = b_neg ? -bus.i_b : bus.i_b;
        // Remainder follows the dividend; product and quotient follow the sign product.
        neg_d    = is_rem(bus.i_op) ? a_neg : (a_neg ^ b_neg);
        div_zero = is_div(bus.i_op) && (bus.i_b == '0);
        ovf      = ((bus.i_op == OP_DIV) || (bus.i_op == OP_REM)) &&
                   (bus.i_a == INT_MIN) && (bus.i_b == '1);
        spec_res = '0;
        if (div_zero) begin
            spec_res = is_rem(bus.i_op) ? bus.i_a : '1;
        end else if (ovf) begin
            spec_res = is_rem(bus.i_op) ? '0 : INT_MIN;
        end
    end

    always_comb begin
        prod     = {hi_d, lo_d};
        prod_fix = neg_q ? -prod : prod;
        rq_sel   = is_rem(op_q) ? hi_d : lo_d;
        if (is_div(op_q)) begin
            final_res = neg_q ? -rq_sel : rq_sel;
        end else if (op_q == OP_MUL) begin
            final_res = prod_fix[DATA_WIDTH-1:0];
        end else begin
            final_res = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q   <= 1'b0;
            result_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        op_q  <= bus.i_op;
                        neg_q <= neg_d;
                        hi_q  <= '0;
                        lo_q  <= a_mag;
                        b_q   <= b_mag;
                        cnt_q <= CNT_LOAD;
                        if (div_zero || ovf) begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= spec_res;
                        end else begin
                            state_q <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (bus.i_flush) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hi_q  <= hi_d;
                        lo_q  <= lo_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CW'(1)) begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            result_q <= final_res;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_stall  = !bus.i_flush &&
                          (((state_q == ST_IDLE) && bus.i_start) || (state_q == ST_BUSY));
    assign bus.o_done   = done_q;
    assign bus.o_result = result_q;
endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Bench for ex_muldiv_sequencer: vector table through a result scoreboard, plus flush/reset sequences.
module tb_ex_muldiv_sequencer;
    import ex_muldiv_sequencer_pkg::*;

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    logic i_clk = 1'b0;
    logic i_rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    logic [31:0] exp_q[$];
    vec_t vec[18];

    ex_muldiv_sequencer_if #(.DATA_WIDTH(32)) bus ();

    ex_muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_op(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input bit hold, input string name);
        int cyc = 0;
        int stall_cnt = 0;
        bit seen = 0;
        bit zero_ok = 1;
        logic [31:0] got = '0;
        logic [31:0] want = '0;
        bus.i_op = op;
        bus.i_a = a;
        bus.i_b = b;
        bus.i_start = 1'b1;
        exp_q.push_back(exp);
        #1;
        while (!seen && cyc <= 40) begin
            if (bus.o_stall) stall_cnt++;
            if (bus.o_done) begin
                seen = 1;
                got = bus.o_result;
            end else if (bus.o_result != 0) begin
                zero_ok = 0;
            end
            if (!seen) begin
                tick();
                cyc++;
                if (!hold) bus.i_start = 1'b0;
            end
        end
        if (!seen) begin
            chk({name, " timeout"}, 32'(cyc), 32'(lat));
            void'(exp_q.pop_front());
        end else begin
            if (exp_q.size() == 0) begin
                chk({name, " unexpected done"}, got, 32'hx);
            end else begin
                want = exp_q.pop_front();
                chk({name, " result"}, got, want);
            end
            chk({name, " latency"}, 32'(cyc), 32'(lat));
            chk({name, " stall cycles"}, 32'(stall_cnt), 32'(lat));
            chk({name, " result zero while not done"}, 32'(zero_ok), 32'd1);
            tick();
            chk({name, " done single pulse"}, 32'(bus.o_done), 32'd0);
        end
        bus.i_start = 1'b0;
    endtask

    task automatic watch_no_done(input int cycles, input string name);
        int pulses = 0;
        for (int k = 0; k < cycles; k++) begin
            tick();
            if (bus.o_done) pulses++;
        end
        chk(name, 32'(pulses), 32'd0);
    endtask

    initial begin
        vec[0]  = '{OP_MUL,    32'd7,        32'd6,        32'd42,       33};
        vec[1]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33};
        vec[2]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
        vec[3]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33};
        vec[4]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33};
        vec[5]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       33};
        vec[6]  = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1};
        vec[7]  = '{OP_REM,    32'd5,        32'd0,        32'd5,        1};
        vec[8]  = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
        vec[9]  = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
        vec[10] = '{OP_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33};
        vec[11] = '{OP_MULH,   32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 33};
        vec[12] = '{OP_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33};
        vec[13] = '{OP_REMU,   32'd100,      32'd7,        32'd2,        33};
        vec[14] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33};
        vec[15] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        33};
        vec[16] = '{OP_REMU,   32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1};
        vec[17] = '{OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33};

        i_rst_n     = 1'b0;
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        bus.i_op    = OP_MUL;
        bus.i_a     = '0;
        bus.i_b     = '0;
        #2;
        chk("reset stall", 32'(bus.o_stall), 32'd0);
        chk("reset done", 32'(bus.o_done), 32'd0);
        chk("reset result", bus.o_result, 32'd0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();

        // Odd entries keep i_start high through BUSY and DONE, as a frozen pipeline would.
        for (int i = 0; i < 18; i++) begin
            run_op(vec[i].op, vec[i].a, vec[i].b, vec[i].exp, vec[i].lat, (i % 2) == 1,
                   $sformatf("vec%0d", i));
        end

        // Flush in the middle of a multiply.
        bus.i_op = OP_MUL;
        bus.i_a = 32'd7;
        bus.i_b = 32'd6;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        repeat (9) tick();
        chk("flush busy stall before", 32'(bus.o_stall), 32'd1);
        bus.i_flush = 1'b1;
        #1;
        chk("flush stall drops same cycle", 32'(bus.o_stall), 32'd0);
        tick();
        bus.i_flush = 1'b0;
        #1;
        chk("flush idle next cycle", 32'(bus.o_stall), 32'd0);
        watch_no_done(40, "flush no done");

        // Start and flush together in IDLE must not launch.
        bus.i_start = 1'b1;
        bus.i_flush = 1'b1;
        #1;
        chk("start+flush stall", 32'(bus.o_stall), 32'd0);
        tick();
        bus.i_start = 1'b0;
        bus.i_flush = 1'b0;
        #1;
        chk("start+flush not busy", 32'(bus.o_stall), 32'd0);
        watch_no_done(40, "start+flush no done");

        // Asynchronous reset in the middle of a divide.
        bus.i_op = OP_DIV;
        bus.i_a = 32'd100;
        bus.i_b = 32'd7;
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
        repeat (14) tick();
        chk("div busy before reset", 32'(bus.o_stall), 32'd1);
        i_rst_n = 1'b0;
        #1;
        chk("midop reset stall", 32'(bus.o_stall), 32'd0);
        chk("midop reset done", 32'(bus.o_done), 32'd0);
        chk("midop reset result", bus.o_result, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        run_op(OP_MULHSU, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 33, 1'b0, "mulhsu after reset");
        watch_no_done(5, "idle after last op");

        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
